// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic       OWN_FETCH  = 1'b0;
    localparam logic       OWN_DATA   = 1'b1;
    localparam logic [3:0] FETCH_MASK = 4'hF;
    localparam logic [3:0] STARVE_MAX = 4'hF;

    // Saturating increment of the fetch-starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt == STARVE_MAX) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational winner select between fetch and data requesters.
module arb_priority #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       i_imem_req,
    input  logic       i_dmem_req,
    input  logic [3:0] i_starve_cnt,
    output logic       o_grant_fetch,
    output logic       o_grant_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic starved;

    // Data normally wins a tie; fetch is forced once it has waited LIMIT grants.
    always_comb begin
        starved       = (i_starve_cnt >= LIMIT);
        o_grant_fetch = i_imem_req && (!i_dmem_req || starved);
        o_grant_data  = i_dmem_req && !o_grant_fetch;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one multi-cycle memory port, one transaction outstanding.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_imem_req,
    input  logic [ADDR_W-1:0] i_imem_addr,
    output logic              o_imem_ready,
    output logic              o_imem_valid,
    output logic [31:0]       o_imem_rdata,
    input  logic              i_dmem_req,
    input  logic [ADDR_W-1:0] i_dmem_addr,
    input  logic              i_dmem_wen,
    input  logic [31:0]       i_dmem_wdata,
    input  logic [3:0]        i_dmem_mask,
    output logic              o_dmem_ready,
    output logic              o_dmem_valid,
    output logic [31:0]       o_dmem_rdata,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_ready,
    input  logic              i_mem_valid,
    input  logic [31:0]       i_mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       o_perf_fetch_grants,
    output logic [31:0]       o_perf_data_grants,
    output logic [31:0]       o_perf_conflict_cycles,
    output logic [31:0]       o_perf_busy_cycles
`endif
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;

    logic grant_fetch;
    logic grant_data;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_priority (
        .i_imem_req    (i_imem_req),
        .i_dmem_req    (i_dmem_req),
        .i_starve_cnt  (starve_cnt_q),
        .o_grant_fetch (grant_fetch),
        .o_grant_data  (grant_data)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;

        o_imem_ready = 1'b0;
        o_imem_valid = 1'b0;
        o_imem_rdata = '0;
        o_dmem_ready = 1'b0;
        o_dmem_valid = 1'b0;
        o_dmem_rdata = '0;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = '0;
        o_mem_mask   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_fetch) begin
                    o_imem_ready = 1'b1;
                    owner_d      = OWN_FETCH;
                    addr_d       = i_imem_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    mask_d       = FETCH_MASK;
                    starve_cnt_d = '0;
                    state_d      = ARB_ISSUE;
                end else if (grant_data) begin
                    o_dmem_ready = 1'b1;
                    owner_d      = OWN_DATA;
                    addr_d       = i_dmem_addr;
                    wen_d        = i_dmem_wen;
                    wdata_d      = i_dmem_wdata;
                    mask_d       = i_dmem_mask;
                    starve_cnt_d = i_imem_req ? starve_inc(starve_cnt_q) : starve_cnt_q;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                o_mem_req   = 1'b1;
                o_mem_addr  = addr_q;
                o_mem_wen   = wen_q;
                o_mem_wdata = wdata_q;
                o_mem_mask  = mask_q;
                if (i_mem_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (i_mem_valid) begin
                    if (owner_q == OWN_DATA) begin
                        o_dmem_valid = 1'b1;
                        o_dmem_rdata = i_mem_rdata;
                    end else begin
                        o_imem_valid = 1'b1;
                        o_imem_rdata = i_mem_rdata;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Reset is synchronous, so outputs are forced quiet while it is held.
        if (!i_rst_n) begin
            o_imem_ready = 1'b0;
            o_imem_valid = 1'b0;
            o_imem_rdata = '0;
            o_dmem_ready = 1'b0;
            o_dmem_valid = 1'b0;
            o_dmem_rdata = '0;
            o_mem_req    = 1'b0;
            o_mem_addr   = '0;
            o_mem_wen    = 1'b0;
            o_mem_wdata  = '0;
            o_mem_mask   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_FETCH;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_data_q, perf_data_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_fetch_d    = perf_fetch_q;
        perf_data_d     = perf_data_q;
        perf_conflict_d = perf_conflict_q;
        perf_busy_d     = perf_busy_q;
        if (o_imem_ready) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (o_dmem_ready) begin
            perf_data_d = perf_data_q + 32'd1;
        end
        if ((state_q == ARB_IDLE) && i_imem_req && i_dmem_req) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
        if (state_q != ARB_IDLE) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_fetch_q    <= '0;
            perf_data_q     <= '0;
            perf_conflict_q <= '0;
            perf_busy_q     <= '0;
        end else begin
            perf_fetch_q    <= perf_fetch_d;
            perf_data_q     <= perf_data_d;
            perf_conflict_q <= perf_conflict_d;
            perf_busy_q     <= perf_busy_d;
        end
    end

    assign o_perf_fetch_grants    = perf_fetch_q;
    assign o_perf_data_grants     = perf_data_q;
    assign o_perf_conflict_cycles = perf_conflict_q;
    assign o_perf_busy_cycles     = perf_busy_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_ready, dmem_valid;
    logic [31:0] dmem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_fetch, perf_data, perf_conflict, perf_busy;
`endif

    mem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (32)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_imem_req   (imem_req),
        .i_imem_addr  (imem_addr),
        .o_imem_ready (imem_ready),
        .o_imem_valid (imem_valid),
        .o_imem_rdata (imem_rdata),
        .i_dmem_req   (dmem_req),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_wen   (dmem_wen),
        .i_dmem_wdata (dmem_wdata),
        .i_dmem_mask  (dmem_mask),
        .o_dmem_ready (dmem_ready),
        .o_dmem_valid (dmem_valid),
        .o_dmem_rdata (dmem_rdata),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .o_mem_wen    (mem_wen),
        .o_mem_wdata  (mem_wdata),
        .o_mem_mask   (mem_mask),
        .i_mem_ready  (mem_ready),
        .i_mem_valid  (mem_valid),
        .i_mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .o_perf_fetch_grants    (perf_fetch),
        .o_perf_data_grants     (perf_data),
        .o_perf_conflict_cycles (perf_conflict),
        .o_perf_busy_cycles     (perf_busy)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding transaction record plus a starvation tally.
    bit          m_busy;
    bit          m_accepted;
    bit          m_is_data;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_mask;
    int          m_starve;
    int unsigned m_pf, m_pd, m_pc, m_pb;
    bit          g_f, g_d, resp;
    bit          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_accepted = 0; m_is_data = 0;
        m_addr = '0; m_wdata = '0; m_wen = 0; m_mask = '0;
        m_starve = 0;
        m_pf = 0; m_pd = 0; m_pc = 0; m_pb = 0;
    endtask

    task automatic settle();
        logic        e_mreq, e_mwen, e_iv, e_dv;
        logic [31:0] e_maddr, e_mwd, e_ird, e_drd;
        logic [3:0]  e_mmask;
        #1;
        e_mreq = 0; e_mwen = 0; e_iv = 0; e_dv = 0;
        e_maddr = '0; e_mwd = '0; e_ird = '0; e_drd = '0; e_mmask = '0;
        g_f = 0; g_d = 0; resp = 0;
        if (rst_n) begin
            if (!m_busy) begin
                if (imem_req && (!dmem_req || m_starve >= LIMIT)) g_f = 1;
                else if (dmem_req) g_d = 1;
            end else if (!m_accepted) begin
                e_mreq = 1; e_maddr = m_addr; e_mwen = m_wen;
                e_mwd = m_wdata; e_mmask = m_mask;
            end else if (mem_valid) begin
                resp = 1;
                if (m_is_data) begin e_dv = 1; e_drd = mem_rdata; end
                else begin e_iv = 1; e_ird = mem_rdata; end
            end
        end
        chk("imem_ready", imem_ready, g_f);
        chk("dmem_ready", dmem_ready, g_d);
        chk("imem_valid", imem_valid, e_iv);
        chk("dmem_valid", dmem_valid, e_dv);
        chk("imem_rdata", imem_rdata, e_ird);
        chk("dmem_rdata", dmem_rdata, e_drd);
        chk("mem_req", mem_req, e_mreq);
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_wen", mem_wen, e_mwen);
        chk("mem_wdata", mem_wdata, e_mwd);
        chk("mem_mask", mem_mask, e_mmask);
`ifdef MEM_ARB_PERF_EN
        chk("perf_fetch", perf_fetch, m_pf);
        chk("perf_data", perf_data, m_pd);
        chk("perf_conflict", perf_conflict, m_pc);
        chk("perf_busy", perf_busy, m_pb);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!m_busy && imem_req && dmem_req) m_pc++;
            if (m_busy) m_pb++;
            if (g_f) begin
                m_pf++;
                grants.push_back(1'b0);
                m_busy = 1; m_accepted = 0; m_is_data = 0;
                m_addr = imem_addr; m_wen = 0; m_wdata = '0; m_mask = 4'hF;
                m_starve = 0;
            end else if (g_d) begin
                m_pd++;
                grants.push_back(1'b1);
                m_busy = 1; m_accepted = 0; m_is_data = 1;
                m_addr = dmem_addr; m_wen = dmem_wen; m_wdata = dmem_wdata; m_mask = dmem_mask;
                if (imem_req && m_starve < 15) m_starve++;
            end else if (m_busy && !m_accepted && mem_ready) begin
                m_accepted = 1;
            end else if (resp) begin
                m_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        model_reset();
        rst_n = 0; imem_req = 0; imem_addr = '0; dmem_req = 0; dmem_addr = '0;
        dmem_wen = 0; dmem_wdata = '0; dmem_mask = '0;
        mem_ready = 0; mem_valid = 0; mem_rdata = '0;
        @(negedge clk);
        settle(); tick();
        settle(); tick();
        rst_n = 1;

        // Fetch alone with minimum latency.
        imem_req = 1; imem_addr = 32'h100;
        settle(); chk("fetch_ready_c0", imem_ready, 1); tick();
        imem_req = 0; mem_ready = 1;
        settle();
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_mask", mem_mask, 4'hF);
        chk("fetch_wen", mem_wen, 0);
        tick();
        mem_ready = 0; mem_valid = 1; mem_rdata = 32'h0000_0013;
        settle();
        chk("fetch_valid_c2", imem_valid, 1);
        chk("fetch_rdata", imem_rdata, 32'h13);
        tick();
        mem_valid = 0;

        // Store with memory ready delayed three cycles.
        dmem_req = 1; dmem_addr = 32'h2000; dmem_wen = 1; dmem_wdata = 32'hAB00_0000; dmem_mask = 4'b1000;
        settle(); chk("store_ready", dmem_ready, 1); tick();
        dmem_req = 0; dmem_addr = '0; dmem_wdata = '0; dmem_mask = '0; dmem_wen = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("store_hold_addr", mem_addr, 32'h2000);
            chk("store_hold_wdata", mem_wdata, 32'hAB00_0000);
            chk("store_hold_mask", mem_mask, 4'b1000);
            chk("store_hold_wen", mem_wen, 1);
            tick();
        end
        mem_ready = 1;
        settle(); tick();
        mem_ready = 0; mem_valid = 1; mem_rdata = $urandom;
        settle();
        chk("store_ack_dvalid", dmem_valid, 1);
        chk("store_ack_ivalid", imem_valid, 0);
        tick();
        mem_valid = 0;

        // Spurious response while idle.
        mem_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("spurious_ivalid", imem_valid, 0);
        chk("spurious_dvalid", dmem_valid, 0);
        tick();
        mem_valid = 0; imem_req = 1; imem_addr = 32'h104;
        settle(); chk("post_spurious_ready", imem_ready, 1); tick();
        imem_req = 0; mem_ready = 1;
        settle(); tick();
        mem_ready = 0; mem_valid = 1;
        settle(); tick();
        mem_valid = 0;

        // Reset while waiting on the response; late response is dropped.
        imem_req = 1; imem_addr = 32'h200;
        settle(); tick();
        imem_req = 0; mem_ready = 1;
        settle(); tick();
        mem_ready = 0; rst_n = 0;
        settle(); tick();
        rst_n = 1; mem_valid = 1; mem_rdata = 32'h1234_5678;
        settle();
        chk("rst_late_ivalid", imem_valid, 0);
        chk("rst_late_mreq", mem_req, 0);
        tick();
        mem_valid = 0;

        // Continuous contention: fetch forced every fifth grant.
        grants.delete();
        imem_req = 1; dmem_req = 1; mem_ready = 1; mem_valid = 1;
        imem_addr = $urandom & 32'hFFFF_FFFC; dmem_addr = $urandom & 32'hFFFF_FFFC;
        n = 0;
        while (grants.size() < 15 && n < 200) begin
            settle();
            if (g_f) chk("starve_before_fetch", u_dut.starve_cnt_q, LIMIT);
            tick();
            imem_addr = $urandom & 32'hFFFF_FFFC; dmem_addr = $urandom & 32'hFFFF_FFFC;
            dmem_wen = $urandom_range(0, 1); dmem_wdata = $urandom; dmem_mask = 4'($urandom);
            mem_rdata = $urandom;
            n++;
        end
        if (grants.size() < 15) chk("contention_timeout", grants.size(), 15);
        for (int i = 0; i < grants.size() && i < 15; i++) begin
            chk("grant_order", {31'd0, grants[i]}, (i % 5 == 4) ? 32'd0 : 32'd1);
        end
        imem_req = 0; dmem_req = 0; mem_ready = 0; mem_valid = 0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!imem_req || g_f) begin
                imem_req = ($urandom_range(0, 2) == 0);
                imem_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dmem_req || g_d) begin
                dmem_req = ($urandom_range(0, 2) == 0);
                dmem_addr = $urandom & 32'hFFFF_FFFC;
                dmem_wen = $urandom_range(0, 1);
                dmem_wdata = $urandom;
                dmem_mask = 4'($urandom);
            end
            mem_ready = $urandom_range(0, 1);
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
